id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, flush and back-pressure
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [RA_W-1:0]   rs1_addr,
    input  logic [RA_W-1:0]   rs2_addr,
    input  logic [RA_W-1:0]   rd_addr,
    input  logic              use_imm,
    input  logic              reg_write_in,
    input  logic [3:0]        alu_sel_in,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic              exmem_we,
    input  logic              memwb_we,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic [DATA_W-1:0] memwb_res,
    input  logic              flush,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    output logic [RA_W-1:0]   rd_out,
    output logic              reg_write_out,
    output logic              out_valid,
    output logic [31:0]       stall_cnt
);

    logic              out_valid_q, out_valid_d;
    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    logic [31:0]       stall_q, stall_d;
    logic              capture;
    logic              is_shift;
    logic [DATA_W-1:0] op1, op2;

    // The EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [RA_W-1:0]   addr,
        input logic [DATA_W-1:0] rf,
        input logic [RA_W-1:0]   em_rd,
        input logic              em_we,
        input logic [DATA_W-1:0] em_res,
        input logic [RA_W-1:0]   mw_rd,
        input logic              mw_we,
        input logic [DATA_W-1:0] mw_res
    );
        if (addr == '0)                      return rf;
        else if (em_we && em_rd == addr)     return em_res;
        else if (mw_we && mw_rd == addr)     return mw_res;
        else                                 return rf;
    endfunction

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;
    assign is_shift = (alu_sel_in == 4'b0110) || (alu_sel_in == 4'b0111) || (alu_sel_in == 4'b1000);

    always_comb begin
        op1 = fwd(rs1_addr, rs1_data, exmem_rd, exmem_we, exmem_res, memwb_rd, memwb_we, memwb_res);
        op2 = fwd(rs2_addr, rs2_data, exmem_rd, exmem_we, exmem_res, memwb_rd, memwb_we, memwb_res);

        out_valid_d = out_valid_q;
        reg_write_d = reg_write_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        stall_d     = stall_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            alu_a_d     = (alu_sel_in == 4'b0101) ? imm : op1;
            if (use_imm)
                alu_b_d = is_shift ? {{(DATA_W-5){1'b0}}, imm[4:0]} : imm;
            else
                alu_b_d = op2;
            alu_sel_d   = (alu_sel_in > 4'b1000) ? 4'b0000 : alu_sel_in;
            rd_d        = rd_addr;
            reg_write_d = reg_write_in && (rd_addr != '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && !out_ready && !flush && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rd_q        <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            reg_write_q <= reg_write_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign reg_write_out = reg_write_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign rd_out        = rd_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        use_imm, reg_write_in;
    logic [3:0]  alu_sel_in;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_res, memwb_res;
    logic        flush, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [4:0]  rd_out;
    logic        reg_write_out, out_valid;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic        mv;
    logic [31:0] exp_stall;
    int          n_checks = 0;
    int          n_errors = 0;

    id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .use_imm(use_imm), .reg_write_in(reg_write_in), .alu_sel_in(alu_sel_in),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .exmem_res(exmem_res), .memwb_res(memwb_res), .flush(flush), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .out_valid(out_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [4:0] addr, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (addr != 5'd0) begin
            if (exmem_we && exmem_rd == addr)      v = exmem_res;
            else if (memwb_we && memwb_rd == addr) v = memwb_res;
        end
        return v;
    endfunction

    function automatic exp_t ref_model();
        exp_t e;
        e.a   = (alu_sel_in == 4'b0101) ? imm : ref_op(rs1_addr, rs1_data);
        if (!use_imm)                                     e.b = ref_op(rs2_addr, rs2_data);
        else if (alu_sel_in >= 4'd6 && alu_sel_in <= 4'd8) e.b = {27'd0, imm[4:0]};
        else                                              e.b = imm;
        e.sel = (alu_sel_in > 4'd8) ? 4'd0 : alu_sel_in;
        e.rd  = rd_addr;
        e.we  = reg_write_in && (rd_addr != 5'd0);
        return e;
    endfunction

    // One clock: inputs are already set; check at the falling edge, then advance the model.
    task automatic cycle();
        logic exp_ready;
        exp_t f;
        @(negedge clk);
        exp_ready = !flush && (!mv || out_ready);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, mv});
        check("stall_cnt", stall_cnt, exp_stall);
        if (mv) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                f = sb[0];
                check("alu_a", alu_a, f.a);
                check("alu_b", alu_b, f.b);
                check("alu_sel", {28'd0, alu_sel}, {28'd0, f.sel});
                check("rd_out", {27'd0, rd_out}, {27'd0, f.rd});
                check("reg_write_out", {31'd0, reg_write_out}, {31'd0, f.we});
                if (out_ready || flush) void'(sb.pop_front());
            end
        end
        if (mv && !out_ready && !flush && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        if (flush)                       mv = 1'b0;
        else if (in_valid && exp_ready) begin sb.push_back(ref_model()); mv = 1'b1; end
        else if (out_ready)              mv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                             input logic [31:0] d2, input logic [3:0] sel, input logic ui,
                             input logic [31:0] im, input logic [4:0] rd, input logic rw);
        rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
        alu_sel_in = sel; use_imm = ui; imm = im; rd_addr = rd; reg_write_in = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb.delete();
        mv = 1'b0;
        exp_stall = 32'd0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_fields", {22'd0, alu_sel, rd_out, reg_write_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 1;
        exmem_rd = 0; memwb_rd = 0; exmem_we = 0; memwb_we = 0; exmem_res = 0; memwb_res = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mv = 0; exp_stall = 0;
        #12;
        do_reset();

        // plain issue
        set_instr(1, 32'd5, 2, 32'd7, 4'b0000, 0, 0, 5'd4, 1);
        in_valid = 1; cycle();
        in_valid = 0; cycle();

        // forwarding priority
        exmem_rd = 3; exmem_we = 1; exmem_res = 32'h11;
        memwb_rd = 3; memwb_we = 1; memwb_res = 32'h22;
        set_instr(3, 32'h99, 9, 32'h5, 4'b0000, 0, 0, 5'd6, 1);
        in_valid = 1; cycle();
        exmem_we = 0; cycle();
        exmem_we = 1; exmem_rd = 0; memwb_rd = 0;
        set_instr(0, 32'h77, 0, 32'h66, 4'b0001, 0, 0, 5'd0, 1);
        cycle();
        memwb_rd = 9; set_instr(1, 32'h1, 9, 32'h2, 4'b0010, 0, 0, 5'd7, 0);
        cycle();
        in_valid = 0; exmem_we = 0; memwb_we = 0; cycle();

        // back-pressure then drain-and-capture
        set_instr(1, 32'hA1, 2, 32'hB2, 4'b0011, 0, 0, 5'd8, 1);
        out_ready = 0; in_valid = 1; cycle();
        set_instr(1, 32'hC3, 2, 32'hD4, 4'b0100, 0, 0, 5'd9, 1);
        repeat (4) cycle();
        check("stall_after_4", stall_cnt, 32'd4);
        out_ready = 1; cycle();
        in_valid = 0; cycle();

        // immediate forms
        in_valid = 1;
        set_instr(1, 32'h5, 2, 32'h6, 4'b0110, 1, 32'hFFFF_FFE3, 5'd1, 1); cycle();
        set_instr(1, 32'h5, 2, 32'h6, 4'b0101, 1, 32'h1234, 5'd2, 1); cycle();
        set_instr(1, 32'h5, 2, 32'h6, 4'b1111, 0, 0, 5'd3, 1); cycle();
        set_instr(1, 32'h5, 2, 32'h6, 4'b0000, 1, 32'hFFFF_FF80, 5'd3, 1); cycle();
        in_valid = 0; cycle();

        // flush with held instruction and a competing input
        set_instr(1, 32'hE1, 2, 32'hE2, 4'b0001, 0, 0, 5'd5, 1);
        in_valid = 1; out_ready = 0; cycle();
        set_instr(1, 32'hF1, 2, 32'hF2, 4'b0010, 0, 0, 5'd6, 1);
        flush = 1; cycle();
        flush = 0; in_valid = 0; out_ready = 1; cycle();
        cycle();

        // random traffic
        for (int i = 0; i < 60; i++) begin
            set_instr($urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom,
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            exmem_rd = $urandom_range(0, 7); exmem_we = 1'($urandom_range(0, 1)); exmem_res = $urandom;
            memwb_rd = $urandom_range(0, 7); memwb_we = 1'($urandom_range(0, 1)); memwb_res = $urandom;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            cycle();
        end
        flush = 0; in_valid = 0; out_ready = 1; cycle();

        // reset in the middle of a stall
        do_reset();
        set_instr(1, 32'h10, 2, 32'h20, 4'b0000, 0, 0, 5'd1, 1);
        in_valid = 1; out_ready = 0; cycle();
        in_valid = 0; repeat (9) cycle();
        check("stall_before_rst", stall_cnt, 32'd9);
        check("valid_before_rst", {31'd0, out_valid}, 32'd1);
        do_reset();
        out_ready = 1;
        set_instr(1, 32'h30, 2, 32'h40, 4'b0000, 0, 0, 5'd2, 1);
        in_valid = 1; cycle();
        in_valid = 0; cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
